// File: rtl/dbg_port_arbiter_pkg.sv
// Shared definitions for the debug-port arbiter: FSM encoding, requester index
// width, default port widths matching the core's register and bus widths.
package dbg_arb_defs;

  localparam int unsigned IDX_BITS          = 1;
  localparam int unsigned DEF_REG_ADDR_BITS = 5;
  localparam int unsigned DEF_MEM_ADDR_BITS = 32;
  localparam int unsigned DEF_DATA_BITS     = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    ACCESS  = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  function automatic logic [1:0] idx_to_onehot(input logic [IDX_BITS-1:0] idx);
    return (idx == 1'b1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dbg_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes to
// the requester that was not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       idx
);

  // select winner index from the request pattern and last-served pointer
  always_comb begin
    case (req)
      2'b01:   idx = 1'b0;
      2'b10:   idx = 1'b1;
      2'b11:   idx = ~last;
      default: idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/dbg_port_arbiter.sv
// Arbitrates the core's single debug path (register port, memory port,
// op_req, halt, reset) between the JTAG debug module and the UART loader.
module dbg_port_arbiter
  import dbg_arb_defs::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned REG_ADDR_BITS = DEF_REG_ADDR_BITS,
  parameter int unsigned MEM_ADDR_BITS = DEF_MEM_ADDR_BITS,
  parameter int unsigned DATA_BITS     = DEF_DATA_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               rq_op_req_i,
  input  logic [1:0]               rq_halt_req_i,
  input  logic [1:0]               rq_reset_req_i,
  input  logic                     rq0_reg_we_i,
  input  logic [REG_ADDR_BITS-1:0] rq0_reg_addr_i,
  input  logic [DATA_BITS-1:0]     rq0_reg_wdata_i,
  input  logic                     rq0_mem_we_i,
  input  logic [MEM_ADDR_BITS-1:0] rq0_mem_addr_i,
  input  logic [DATA_BITS-1:0]     rq0_mem_wdata_i,
  input  logic                     rq1_reg_we_i,
  input  logic [REG_ADDR_BITS-1:0] rq1_reg_addr_i,
  input  logic [DATA_BITS-1:0]     rq1_reg_wdata_i,
  input  logic                     rq1_mem_we_i,
  input  logic [MEM_ADDR_BITS-1:0] rq1_mem_addr_i,
  input  logic [DATA_BITS-1:0]     rq1_mem_wdata_i,
  output logic [1:0]               gnt_o,
  output logic [DATA_BITS-1:0]     reg_rdata_o,
  output logic [DATA_BITS-1:0]     mem_rdata_o,
  output logic                     reg_we_o,
  output logic [REG_ADDR_BITS-1:0] reg_addr_o,
  output logic [DATA_BITS-1:0]     reg_wdata_o,
  input  logic [DATA_BITS-1:0]     reg_rdata_i,
  output logic                     mem_we_o,
  output logic [MEM_ADDR_BITS-1:0] mem_addr_o,
  output logic [DATA_BITS-1:0]     mem_wdata_o,
  input  logic [DATA_BITS-1:0]     mem_rdata_i,
  output logic                     op_req_o,
  output logic                     halt_req_o,
  output logic                     reset_req_o
);

  localparam int unsigned CNT_BITS = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  arb_state_e            state_r, state_nxt_s;
  logic [CNT_BITS-1:0]   cnt_r, cnt_nxt_s;
  logic [IDX_BITS-1:0]   owner_r, owner_nxt_s;
  logic                  last_r, last_nxt_s;
  logic                  reset_req_r, reset_req_nxt_s;
  logic                  pick_s;
  logic                  owner_op_s;

  rr_arb2 u_rr_arb2 (
    .req  (rq_op_req_i),
    .last (last_r),
    .idx  (pick_s)
  );

  assign owner_op_s = rq_op_req_i[owner_r];

  // state, owner, last-served, settle counter and core-reset registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      owner_r     <= 1'b0;
      last_r      <= 1'b1;
      reset_req_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      owner_r     <= owner_nxt_s;
      last_r      <= last_nxt_s;
      reset_req_r <= reset_req_nxt_s;
    end
  end

  // next-state logic; an owner drop always beats counter expiry
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    owner_nxt_s     = owner_r;
    last_nxt_s      = last_r;
    reset_req_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        reset_req_nxt_s = |rq_reset_req_i;
        if (|rq_op_req_i) begin
          owner_nxt_s = pick_s;
          cnt_nxt_s   = CNT_BITS'(SETTLE_CYCLES - 1);
          state_nxt_s = SETTLE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETTLE: begin
        if (!owner_op_s) begin
          state_nxt_s = RELEASE;
        end else if (cnt_r == '0) begin
          state_nxt_s = ACCESS;
        end else begin
          cnt_nxt_s = cnt_r - CNT_BITS'(1);
        end
      end
      ACCESS: begin
        reset_req_nxt_s = rq_reset_req_i[owner_r];
        if (!owner_op_s) begin
          state_nxt_s = RELEASE;
          last_nxt_s  = owner_r;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      RELEASE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // output decode; only the owner's port reaches the core while in ACCESS
  always_comb begin
    gnt_o       = 2'b00;
    op_req_o    = 1'b0;
    halt_req_o  = |rq_halt_req_i;
    reg_we_o    = 1'b0;
    reg_addr_o  = '0;
    reg_wdata_o = '0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    reg_rdata_o = '0;
    mem_rdata_o = '0;
    reset_req_o = reset_req_r;
    case (state_r)
      SETTLE: begin
        op_req_o   = 1'b1;
        halt_req_o = 1'b1;
      end
      ACCESS: begin
        gnt_o       = idx_to_onehot(owner_r);
        op_req_o    = 1'b1;
        halt_req_o  = 1'b1;
        reg_rdata_o = reg_rdata_i;
        mem_rdata_o = mem_rdata_i;
        if (owner_r == 1'b1) begin
          reg_we_o    = rq1_reg_we_i;
          reg_addr_o  = rq1_reg_addr_i;
          reg_wdata_o = rq1_reg_wdata_i;
          mem_we_o    = rq1_mem_we_i;
          mem_addr_o  = rq1_mem_addr_i;
          mem_wdata_o = rq1_mem_wdata_i;
        end else begin
          reg_we_o    = rq0_reg_we_i;
          reg_addr_o  = rq0_reg_addr_i;
          reg_wdata_o = rq0_reg_wdata_i;
          mem_we_o    = rq0_mem_we_i;
          mem_addr_o  = rq0_mem_addr_i;
          mem_wdata_o = rq0_mem_wdata_i;
        end
      end
      IDLE, RELEASE: begin
        op_req_o = 1'b0;
      end
      default: begin
        op_req_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dbg_port_arbiter.sv
// Directed plus randomized bench for dbg_port_arbiter, checked against a
// session-level model of grant timing, ownership and port routing.
module tb_dbg_port_arbiter;

  localparam int S = 4;

  logic        clk;
  logic        rst;
  logic [1:0]  rq_op, rq_halt, rq_rst;
  logic        rq0_reg_we, rq1_reg_we, rq0_mem_we, rq1_mem_we;
  logic [4:0]  rq0_reg_addr, rq1_reg_addr;
  logic [31:0] rq0_reg_wdata, rq1_reg_wdata;
  logic [31:0] rq0_mem_addr, rq1_mem_addr, rq0_mem_wdata, rq1_mem_wdata;
  logic [31:0] reg_rdata_i, mem_rdata_i;
  logic [1:0]  gnt_o;
  logic [31:0] reg_rdata_o, mem_rdata_o, reg_wdata_o, mem_addr_o, mem_wdata_o;
  logic [4:0]  reg_addr_o;
  logic        reg_we_o, mem_we_o, op_req_o, halt_req_o, reset_req_o;

  int errors = 0;
  int checks = 0;
  int last_model;

  dbg_port_arbiter #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .rq_op_req_i(rq_op), .rq_halt_req_i(rq_halt), .rq_reset_req_i(rq_rst),
    .rq0_reg_we_i(rq0_reg_we), .rq0_reg_addr_i(rq0_reg_addr), .rq0_reg_wdata_i(rq0_reg_wdata),
    .rq0_mem_we_i(rq0_mem_we), .rq0_mem_addr_i(rq0_mem_addr), .rq0_mem_wdata_i(rq0_mem_wdata),
    .rq1_reg_we_i(rq1_reg_we), .rq1_reg_addr_i(rq1_reg_addr), .rq1_reg_wdata_i(rq1_reg_wdata),
    .rq1_mem_we_i(rq1_mem_we), .rq1_mem_addr_i(rq1_mem_addr), .rq1_mem_wdata_i(rq1_mem_wdata),
    .gnt_o(gnt_o), .reg_rdata_o(reg_rdata_o), .mem_rdata_o(mem_rdata_o),
    .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
    .reg_rdata_i(reg_rdata_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .op_req_o(op_req_o), .halt_req_o(halt_req_o), .reset_req_o(reset_req_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"}, 64'(gnt_o), 64'd0);
    chk({tag, "_op"}, 64'(op_req_o), 64'd0);
    chk({tag, "_regwe"}, 64'(reg_we_o), 64'd0);
    chk({tag, "_memwe"}, 64'(mem_we_o), 64'd0);
  endtask

  function automatic logic [1:0] onehot(input int idx);
    return (idx == 1) ? 2'b10 : 2'b01;
  endfunction

  initial begin
    rq_halt = 2'b00; rq_rst = 2'b00;
    rq0_reg_we = 1'b0; rq1_reg_we = 1'b0; rq0_mem_we = 1'b0; rq1_mem_we = 1'b0;
    rq0_reg_addr = 5'd0; rq1_reg_addr = 5'd0; rq0_reg_wdata = 32'd0; rq1_reg_wdata = 32'd0;
    rq0_mem_addr = 32'd0; rq1_mem_addr = 32'd0; rq0_mem_wdata = 32'd0; rq1_mem_wdata = 32'd0;
    reg_rdata_i = 32'hA5A5_A5A5; mem_rdata_i = 32'h5A5A_5A5A;

    // reset with both requesting
    rst = 1'b1; rq_op = 2'b11;
    tick(); tick();
    chk_quiet("reset");
    chk("reset_halt", 64'(halt_req_o), 64'd0);
    chk("reset_rstreq", 64'(reset_req_o), 64'd0);
    chk("reset_rdata", 64'(reg_rdata_o), 64'd0);
    chk("reset_mrdata", 64'(mem_rdata_o), 64'd0);
    last_model = 1;

    // first IDLE cycle, then S settle cycles, then grant to requester 0
    rst = 1'b0; #1;
    chk("idle0_gnt", 64'(gnt_o), 64'd0);
    chk("idle0_halt", 64'(halt_req_o), 64'd0);
    for (int i = 0; i < S; i++) begin
      tick();
      chk("settle_gnt", 64'(gnt_o), 64'd0);
      chk("settle_halt", 64'(halt_req_o), 64'd1);
      chk("settle_op", 64'(op_req_o), 64'd1);
    end
    tick();
    chk("first_grant", 64'(gnt_o), 64'b01);

    // non-owner reset request must not reach the core
    rq_rst = 2'b10;
    tick(); chk("prot_rst_a", 64'(reset_req_o), 64'd0);
    tick(); chk("prot_rst_b", 64'(reset_req_o), 64'd0);
    rq_rst = 2'b01; #1;
    chk("own_rst_pre", 64'(reset_req_o), 64'd0);
    tick(); chk("own_rst_post", 64'(reset_req_o), 64'd1);
    rq_rst = 2'b00;
    tick(); chk("own_rst_clr", 64'(reset_req_o), 64'd0);

    // zero-latency read path and non-owner isolation
    reg_rdata_i = 32'h1234_5678; mem_rdata_i = 32'hCAFE_F00D;
    rq1_mem_we = 1'b1; rq0_mem_addr = 32'h0000_0040; rq1_mem_addr = 32'h9999_0000;
    #1;
    chk("rd_reg", 64'(reg_rdata_o), 64'h1234_5678);
    chk("rd_mem", 64'(mem_rdata_o), 64'hCAFE_F00D);
    chk("iso_memwe", 64'(mem_we_o), 64'd0);
    chk("iso_memaddr", 64'(mem_addr_o), 64'h0000_0040);

    // rq0 ends; rq1 pending, gap of RELEASE + IDLE before its grant
    rq_op = 2'b10; rq_halt = 2'b10; rq0_reg_we = 1'b1;
    tick();
    chk_quiet("rel0");
    chk("rel0_halt", 64'(halt_req_o), 64'd1);
    tick();
    chk_quiet("gap0");
    chk("gap0_halt", 64'(halt_req_o), 64'd1);
    rq_halt = 2'b00; rq_op = 2'b11;
    rq1_mem_addr = 32'h1000_0000; rq1_mem_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < S; i++) begin
      tick();
      chk("settle1_gnt", 64'(gnt_o), 64'd0);
      chk("settle1_memwe", 64'(mem_we_o), 64'd0);
    end
    tick();
    chk("second_grant", 64'(gnt_o), 64'b10);
    chk("wr_memwe", 64'(mem_we_o), 64'd1);
    chk("wr_memaddr", 64'(mem_addr_o), 64'h1000_0000);
    chk("wr_memwdata", 64'(mem_wdata_o), 64'hDEAD_BEEF);
    chk("wr_regwe", 64'(reg_we_o), 64'd0);

    // rq1 ends; rq0 pending wins next
    rq_op = 2'b01;
    tick(); chk_quiet("rel1");
    tick(); chk_quiet("gap1");
    for (int i = 0; i < S; i++) tick();
    tick();
    chk("third_grant", 64'(gnt_o), 64'b01);
    rq_op = 2'b00; rq0_reg_we = 1'b0; rq1_mem_we = 1'b0;
    tick(); tick(); tick();
    chk("quiet_gnt", 64'(gnt_o), 64'd0);

    // early abort in second settle cycle
    rq_op = 2'b01;
    tick(); chk("abort_s1_op", 64'(op_req_o), 64'd1);
    tick(); rq_op = 2'b00; #1;
    chk("abort_s2_gnt", 64'(gnt_o), 64'd0);
    tick(); chk("abort_rel_op", 64'(op_req_o), 64'd0);
    chk("abort_rel_halt", 64'(halt_req_o), 64'd0);
    tick(); chk("abort_idle_op", 64'(op_req_o), 64'd0);
    for (int i = 0; i < S + 2; i++) begin
      tick(); chk("abort_nogrant", 64'(gnt_o), 64'd0);
    end

    // reset in the middle of an access
    rq_op = 2'b10;
    for (int i = 0; i < S + 1; i++) tick();
    chk("prerst_grant", 64'(gnt_o), 64'b10);
    rq1_mem_we = 1'b1; rst = 1'b1;
    tick();
    chk_quiet("midrst");
    chk("midrst_halt", 64'(halt_req_o), 64'd0);
    rst = 1'b0; rq_op = 2'b00; rq1_mem_we = 1'b0;
    last_model = 1;
    tick();

    // randomized sessions against the round-robin model
    for (int n = 0; n < 24; n++) begin
      int pat, owner, lat, k;
      logic exp_rst;
      pat = int'($urandom_range(1, 3));
      owner = (pat == 3) ? (1 - last_model) : ((pat == 2) ? 1 : 0);
      rq_op = 2'(pat);
      lat = 0;
      while (gnt_o == 2'b00 && lat < 20) begin
        tick(); lat++;
      end
      chk("rnd_latency", 64'(lat), 64'(S + 1));
      chk("rnd_owner", 64'(gnt_o), 64'(onehot(owner)));
      exp_rst = 1'b0;
      k = int'($urandom_range(1, 5));
      for (int c = 0; c < k; c++) begin
        logic [4:0]  ea;
        logic [31:0] ew, ema, emw;
        logic        erw, emwe;
        rq0_reg_we = 1'($urandom()); rq1_reg_we = 1'($urandom());
        rq0_mem_we = 1'($urandom()); rq1_mem_we = 1'($urandom());
        rq0_reg_addr = 5'($urandom()); rq1_reg_addr = 5'($urandom());
        rq0_reg_wdata = $urandom(); rq1_reg_wdata = $urandom();
        rq0_mem_addr = $urandom(); rq1_mem_addr = $urandom();
        rq0_mem_wdata = $urandom(); rq1_mem_wdata = $urandom();
        reg_rdata_i = $urandom(); mem_rdata_i = $urandom();
        rq_rst = 2'($urandom()); rq_halt = 2'($urandom());
        if (owner == 1) begin
          erw = rq1_reg_we; ea = rq1_reg_addr; ew = rq1_reg_wdata;
          emwe = rq1_mem_we; ema = rq1_mem_addr; emw = rq1_mem_wdata;
        end else begin
          erw = rq0_reg_we; ea = rq0_reg_addr; ew = rq0_reg_wdata;
          emwe = rq0_mem_we; ema = rq0_mem_addr; emw = rq0_mem_wdata;
        end
        #1;
        chk("rnd_gnt", 64'(gnt_o), 64'(onehot(owner)));
        chk("rnd_halt", 64'(halt_req_o), 64'd1);
        chk("rnd_regwe", 64'(reg_we_o), 64'(erw));
        chk("rnd_regaddr", 64'(reg_addr_o), 64'(ea));
        chk("rnd_regwdata", 64'(reg_wdata_o), 64'(ew));
        chk("rnd_memwe", 64'(mem_we_o), 64'(emwe));
        chk("rnd_memaddr", 64'(mem_addr_o), 64'(ema));
        chk("rnd_memwdata", 64'(mem_wdata_o), 64'(emw));
        chk("rnd_regrdata", 64'(reg_rdata_o), 64'(reg_rdata_i));
        chk("rnd_memrdata", 64'(mem_rdata_o), 64'(mem_rdata_i));
        chk("rnd_rstreq", 64'(reset_req_o), 64'(exp_rst));
        exp_rst = rq_rst[owner];
        tick();
      end
      rq_op = 2'b00; rq_rst = 2'b00; rq_halt = 2'($urandom());
      #1;
      chk("rnd_last_rstreq", 64'(reset_req_o), 64'(exp_rst));
      tick();
      chk_quiet("rnd_rel");
      chk("rnd_rel_halt", 64'(halt_req_o), 64'(|rq_halt));
      chk("rnd_rel_rstreq", 64'(reset_req_o), 64'd0);
      last_model = owner;
      rq_halt = 2'b00;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
